// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return-address stack.
//   pc_op_t   : the single operation executed in a cycle
//   pc_decode : fixed-priority strobe decode (ret > call > jump > count_en > hold),
//               also reused by the controller for tracing
package pc_pkg;

  localparam int unsigned PC_ADDR_W      = 4;
  localparam int unsigned PC_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_op_t;

  function automatic pc_op_t pc_decode(input logic ret, input logic call, input logic jump,
                                       input logic count_en);
    if (ret) begin
      return PC_RET;
    end else if (call) begin
      return PC_CALL;
    end else if (jump) begin
      return PC_JUMP;
    end else if (count_en) begin
      return PC_INC;
    end
    return PC_HOLD;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack, single port, one push or one pop per cycle.
//   clk, rst : clock and synchronous active-high reset (clears sp only)
//   push/pop : push din / drop top entry; push when full and pop when empty are ignored
//   din      : value to push
//   dout     : current top entry (undefined while empty)
//   sp       : number of valid entries
//   full     : sp == DEPTH
//   empty    : sp == 0
module return_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SpW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SpW-1:0]   sp,
  output logic             full,
  output logic             empty
);

  // Sized to the full sp range so indexing by sp needs no width adaptation;
  // entries at or above DEPTH are never written.
  logic [WIDTH-1:0] mem [2**SpW];
  logic [SpW-1:0]   sp_q;
  logic [SpW-1:0]   top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp_q == SpW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty && !do_push;
  assign top_idx = sp_q - SpW'(1);
  assign dout    = mem[top_idx];
  assign sp      = sp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + SpW'(1);
    end else if (do_pop) begin
      sp_q <= sp_q - SpW'(1);
    end
  end

  // Storage is deliberately not reset; only sp defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp_q] <= din;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with JUMP/CALL/RET support and a hardware return-address stack.
//   clk, rst    : clock and synchronous active-high reset
//   count_en    : increment PC (mod 2^ADDR_W)
//   jump        : PC <= set_count
//   call        : push PC+1, PC <= set_count (dropped entirely when the stack is full)
//   ret         : PC <= popped return address (no-op when the stack is empty)
//   set_count   : jump/call target
//   count       : registered program address
//   sp          : number of valid stack entries
//   stack_full  : sp == STACK_DEPTH
//   stack_empty : sp == 0
//   overflow    : sticky, call attempted while full
//   underflow   : sticky, ret attempted while empty
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = PC_ADDR_W,
  parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               count_en,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  set_count,
  output logic [ADDR_W-1:0]                  count,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam logic [ADDR_W-1:0] ResetVal = ADDR_W'(RESET_ADDR);

  pc_op_t            op;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_inc;
  logic [ADDR_W-1:0] stack_top;
  logic              push;
  logic              pop;
  logic              overflow_q;
  logic              underflow_q;

  assign op        = pc_decode(ret, call, jump, count_en);
  assign count_inc = count_q + ADDR_W'(1);
  assign push      = (op == PC_CALL) && !stack_full;
  assign pop       = (op == PC_RET) && !stack_empty;

  return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (count_inc),
    .dout  (stack_top),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= ResetVal;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (op)
        PC_INC:  count_q <= count_inc;
        PC_JUMP: count_q <= set_count;
        PC_CALL: begin
          // A call into a full stack is dropped, including its jump.
          if (stack_full) begin
            overflow_q <= 1'b1;
          end else begin
            count_q <= set_count;
          end
        end
        PC_RET: begin
          if (stack_empty) begin
            underflow_q <= 1'b1;
          end else begin
            count_q <= stack_top;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Randomised + directed bench for program_counter_stack with a queue-based reference
// model and a scoreboard: the driver pushes expected post-edge state, a monitor pops
// and compares one entry after every clock edge.
module tb_program_counter_stack;

  localparam int AW  = 4;
  localparam int D   = 2;
  localparam int MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, count_en, jump, call, ret;
  logic [AW-1:0] set_count;
  logic [AW-1:0] count;
  logic [1:0]    sp;
  logic          stack_full, stack_empty, overflow, underflow;

  program_counter_stack #(
    .ADDR_W      (AW),
    .STACK_DEPTH (D),
    .RESET_ADDR  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_en    (count_en),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .set_count   (set_count),
    .count       (count),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int sp;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: the return stack is a plain queue of addresses.
  int   m_count = 0;
  int   m_stack[$];
  bit   m_ovf = 0;
  bit   m_unf = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit ce, input bit jp, input bit cl, input bit rt,
                      input int sc);
    exp_t e;
    rst       = r;
    count_en  = ce;
    jump      = jp;
    call      = cl;
    ret       = rt;
    set_count = AW'(sc);
    if (r) begin
      m_count = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (rt) begin
      if (m_stack.size() == 0) m_unf = 1;
      else m_count = m_stack.pop_back();
    end else if (cl) begin
      if (m_stack.size() == D) begin
        m_ovf = 1;
      end else begin
        m_stack.push_back((m_count + 1) % MOD);
        m_count = sc % MOD;
      end
    end else if (jp) begin
      m_count = sc % MOD;
    end else if (ce) begin
      m_count = (m_count + 1) % MOD;
    end
    e.cnt = m_count;
    e.sp  = m_stack.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: state after each edge is compared against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count",       int'(count),       e.cnt);
      check("sp",          int'(sp),          e.sp);
      check("stack_full",  int'(stack_full),  int'(e.sp == D));
      check("stack_empty", int'(stack_empty), int'(e.sp == 0));
      check("overflow",    int'(overflow),    int'(e.ovf));
      check("underflow",   int'(underflow),   int'(e.unf));
    end
  end

  initial begin
    int waited;
    rst = 1'b1; count_en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; set_count = '0;
    @(posedge clk);
    #2;

    // Reset, then 17 increments with wrap past 15.
    step(1, 0, 0, 0, 0, 0);
    repeat (17) step(0, 1, 0, 0, 0, 0);

    // Call/ret round trip from address 5.
    step(0, 0, 1, 0, 0, 5);
    step(0, 0, 0, 1, 0, 'hA);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // Nested calls into a full stack, then unwind.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 3);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 8);
    step(0, 0, 0, 1, 0, 'hE);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Ret on empty stack, flag stays sticky across a jump.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 7);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 3);

    // Overlapping strobes.
    step(0, 1, 1, 0, 0, 9);
    step(0, 0, 1, 0, 0, 3);
    step(0, 0, 0, 1, 0, 'hB);
    step(0, 0, 0, 1, 1, 'hF);

    // Reset in the middle of nested calls, then ret underflows.
    step(0, 0, 0, 1, 0, 2);
    step(0, 0, 0, 1, 0, 6);
    step(1, 0, 0, 1, 0, 'hC);
    step(0, 0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, MOD - 1)));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
